// File: rtl/i2c_master_multibyte.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_master_multibyte
//  Purpose  : I2C master with configurable register-address and data byte
//             counts. Performs writes, and register reads made of a
//             pointer-write phase, a repeated START and a read phase.
//             Slave ACKs are checked per byte; a NACK aborts to STOP.
//             One state step per rising edge of the 100 kHz tick clock.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_master_multibyte #(
   parameter int REG_BYTES  = 1,
   parameter int DATA_BYTES = 2,
   parameter bit CHECK_ACK  = 1'b1
) (
   input  logic                    clock_100khz,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    rw,
   input  logic [6:0]              slave_address,
   input  logic [8*REG_BYTES-1:0]  reg_address,
   input  logic [8*DATA_BYTES-1:0] write_data,
   output logic [8*DATA_BYTES-1:0] read_data,
   output logic                    busy,
   output logic                    done,
   output logic                    nack,
   input  logic                    i2c_serial_data_input,
   output logic                    i2c_serial_data_output,
   output logic                    i2c_serial_clock
);

   localparam int         c_TX_W    = 8 * (REG_BYTES + DATA_BYTES);
   localparam int         c_RX_W    = 8 * DATA_BYTES;
   localparam logic [3:0] c_REG_END = 4'(REG_BYTES);
   localparam logic [3:0] c_WR_END  = 4'(REG_BYTES + DATA_BYTES);
   localparam logic [3:0] c_RD_END  = 4'(DATA_BYTES);

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_START_A = 4'd1,
      ST_START_B = 4'd2,
      ST_BIT     = 4'd3,
      ST_RS_A    = 4'd4,
      ST_RS_B    = 4'd5,
      ST_RS_C    = 4'd6,
      ST_STOP_A  = 4'd7,
      ST_STOP_B  = 4'd8,
      ST_STOP_C  = 4'd9,
      ST_DONE    = 4'd10
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          phase_q, phase_d;      // P0..P3 within a bit
   logic [3:0]          bit_q, bit_d;          // 0..7 data, 8 = ACK slot
   logic [3:0]          byte_q, byte_d;        // 0 = address byte
   logic                rd_phase_q, rd_phase_d; // after repeated START
   logic                rw_q, rw_d;
   logic [6:0]          addr_q, addr_d;
   logic [c_TX_W-1:0]   tx_sr_q, tx_sr_d;      // {reg, data}, MSB byte next
   logic [c_RX_W-1:0]   rx_sr_q, rx_sr_d;
   logic [c_RX_W-1:0]   read_data_q, read_data_d;
   logic                nack_q, nack_d;

   logic                w_sda;
   logic                w_scl;
   logic                w_is_rx;
   logic                w_is_ack;
   logic                w_last_byte;
   logic [7:0]          w_tx_byte;
   logic                w_tx_bit;

   // Byte-slot classification and the bit currently being transmitted
   always_comb begin
      w_is_rx   = rd_phase_q && (byte_q != 4'd0);
      w_is_ack  = (bit_q == 4'd8);
      if (rd_phase_q)
         w_last_byte = (byte_q == c_RD_END);
      else if (rw_q)
         w_last_byte = (byte_q == c_REG_END);
      else
         w_last_byte = (byte_q == c_WR_END);
      w_tx_byte = (byte_q == 4'd0) ? {addr_q, rd_phase_q} : tx_sr_q[c_TX_W-1 -: 8];
      w_tx_bit  = w_tx_byte[3'd7 - bit_q[2:0]];
   end

   // State register and datapath registers
   always_ff @(posedge clock_100khz) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         phase_q     <= 2'd0;
         bit_q       <= 4'd0;
         byte_q      <= 4'd0;
         rd_phase_q  <= 1'b0;
         rw_q        <= 1'b0;
         addr_q      <= 7'd0;
         tx_sr_q     <= '0;
         rx_sr_q     <= '0;
         read_data_q <= '0;
         nack_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         bit_q       <= bit_d;
         byte_q      <= byte_d;
         rd_phase_q  <= rd_phase_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         tx_sr_q     <= tx_sr_d;
         rx_sr_q     <= rx_sr_d;
         read_data_q <= read_data_d;
         nack_q      <= nack_d;
      end
   end

   // Next-state, datapath updates and bus pin drive
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      bit_d       = bit_q;
      byte_d      = byte_q;
      rd_phase_d  = rd_phase_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      tx_sr_d     = tx_sr_q;
      rx_sr_d     = rx_sr_q;
      read_data_d = read_data_q;
      nack_d      = nack_q;
      w_sda       = 1'b1;
      w_scl       = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               rw_d       = rw;
               addr_d     = slave_address;
               tx_sr_d    = {reg_address, write_data};
               nack_d     = 1'b0;
               rd_phase_d = 1'b0;
               byte_d     = 4'd0;
               state_d    = ST_START_A;
            end
         end
         ST_START_A: begin
            w_sda   = 1'b0;
            state_d = ST_START_B;
         end
         ST_START_B: begin
            w_sda   = 1'b0;
            w_scl   = 1'b0;
            phase_d = 2'd0;
            bit_d   = 4'd0;
            state_d = ST_BIT;
         end
         ST_BIT: begin
            w_scl = (phase_q == 2'd1) || (phase_q == 2'd2);
            if (w_is_ack)
               w_sda = w_is_rx ? w_last_byte : 1'b1;   // ACK all but last rx byte
            else
               w_sda = w_is_rx ? 1'b1 : w_tx_bit;
            if (phase_q == 2'd2) begin
               if (w_is_ack && !w_is_rx && CHECK_ACK && i2c_serial_data_input)
                  nack_d = 1'b1;
               if (!w_is_ack && w_is_rx)
                  rx_sr_d = {rx_sr_q[c_RX_W-2:0], i2c_serial_data_input};
            end
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd3) begin
               if (!w_is_ack) begin
                  bit_d = bit_q + 4'd1;
               end else begin
                  bit_d = 4'd0;
                  if ((byte_q != 4'd0) && !w_is_rx)
                     tx_sr_d = tx_sr_q << 8;
                  if (nack_q)
                     state_d = ST_STOP_A;
                  else if (w_last_byte)
                     state_d = (rw_q && !rd_phase_q) ? ST_RS_A : ST_STOP_A;
                  else
                     byte_d = byte_q + 4'd1;
               end
            end
         end
         ST_RS_A: begin
            w_scl   = 1'b0;
            state_d = ST_RS_B;
         end
         ST_RS_B: begin
            state_d = ST_RS_C;
         end
         ST_RS_C: begin
            w_sda      = 1'b0;
            rd_phase_d = 1'b1;
            byte_d     = 4'd0;
            state_d    = ST_START_B;
         end
         ST_STOP_A: begin
            w_sda   = 1'b0;
            w_scl   = 1'b0;
            state_d = ST_STOP_B;
         end
         ST_STOP_B: begin
            w_sda   = 1'b0;
            state_d = ST_STOP_C;
         end
         ST_STOP_C: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (rw_q && !nack_q)
               read_data_d = rx_sr_q;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign read_data              = read_data_q;
   assign nack                   = nack_q;
   assign busy                   = (state_q != ST_IDLE);
   assign done                   = (state_q == ST_DONE);
   assign i2c_serial_data_output = w_sda;
   assign i2c_serial_clock       = w_scl;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_multibyte.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_master_multibyte
//  Purpose  : Directed self-checking bench for i2c_master_multibyte with a
//             wired-AND slave model and a START/STOP-aware bus monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master_multibyte;

   logic        clk = 1'b0;
   logic        rst_n, start_v, rw_v, sel, slave_drv, nack_addr;
   logic [6:0]  saddr;
   logic [7:0]  reg1;
   logic [15:0] wd1, rd1, reg2;
   logic [31:0] wd2, rd2;
   logic        start1, start2, sdai1, sdai2;
   logic        busy1, done1, nack1, sdao1, scl1;
   logic        busy2, done2, nack2, sdao2, scl2;
   logic        m_sda, m_scl, m_busy, m_done, m_nack;

   int          checks = 0;
   int          errors = 0;
   int          ncap, nstart, nstop, ndone, tdone, tdone2, nrd;
   logic [7:0]  cap_byte [32];
   logic        cap_ack  [32];
   logic [7:0]  rdata    [8];
   logic        scl_tr [512];
   logic        sda_tr [512];
   logic        busy_tr[512];
   logic        nack_tr[512];

   always #5 clk = ~clk;

   assign start1 = start_v & ~sel;
   assign start2 = start_v & sel;
   assign sdai1  = sdao1 & slave_drv;
   assign sdai2  = sdao2 & slave_drv;
   assign m_sda  = sel ? sdao2 : sdao1;
   assign m_scl  = sel ? scl2  : scl1;
   assign m_busy = sel ? busy2 : busy1;
   assign m_done = sel ? done2 : done1;
   assign m_nack = sel ? nack2 : nack1;

   i2c_master_multibyte dut1 (
      .clock_100khz(clk), .reset(rst_n), .start(start1), .rw(rw_v),
      .slave_address(saddr), .reg_address(reg1), .write_data(wd1),
      .read_data(rd1), .busy(busy1), .done(done1), .nack(nack1),
      .i2c_serial_data_input(sdai1), .i2c_serial_data_output(sdao1),
      .i2c_serial_clock(scl1)
   );

   i2c_master_multibyte #(.REG_BYTES(2), .DATA_BYTES(4), .CHECK_ACK(1'b1)) dut2 (
      .clock_100khz(clk), .reset(rst_n), .start(start2), .rw(rw_v),
      .slave_address(saddr), .reg_address(reg2), .write_data(wd2),
      .read_data(rd2), .busy(busy2), .done(done2), .nack(nack2),
      .i2c_serial_data_input(sdai2), .i2c_serial_data_output(sdao2),
      .i2c_serial_clock(scl2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs cycles t1..tmax after a t0 in which start was already raised.
   task automatic run(input int tmax, input int hold_until, input int pulse_at, input int rst_at);
      logic       pscl, psda, cscl, csda, b;
      int         bitcnt, nbyte;
      logic       rseg;
      logic [7:0] sh;
      pscl = 1'b1; psda = 1'b1; bitcnt = 0; nbyte = 0; rseg = 1'b0; sh = 8'h00;
      ncap = 0; nstart = 0; nstop = 0; ndone = 0; tdone = -1; tdone2 = -1;
      slave_drv = 1'b1;
      for (int i = 0; i < 32; i++) begin cap_byte[i] = 8'hxx; cap_ack[i] = 1'bx; end
      for (int t = 1; t <= tmax; t++) begin
         @(posedge clk); #1;
         if (t == hold_until) start_v = 1'b0;
         if (t == pulse_at) start_v = 1'b1;
         if (t == pulse_at + 1) start_v = 1'b0;
         if (t == rst_at) rst_n = 1'b0;
         if (t == rst_at + 1) rst_n = 1'b1;
         cscl = m_scl; csda = m_sda; b = csda & slave_drv;
         scl_tr[t] = cscl; sda_tr[t] = csda; busy_tr[t] = m_busy; nack_tr[t] = m_nack;
         if (m_done) begin
            ndone++;
            if (ndone == 1) tdone = t; else tdone2 = t;
         end
         if (pscl && cscl && psda && !csda) begin
            nstart++; bitcnt = 0; nbyte = 0; rseg = 1'b0; slave_drv = 1'b1;
         end else if (pscl && cscl && !psda && csda) begin
            nstop++; bitcnt = 0; slave_drv = 1'b1;
         end else if (!pscl && cscl) begin
            if (bitcnt < 8) sh = {sh[6:0], b};
            bitcnt++;
            if (bitcnt == 9) begin
               if (ncap < 32) begin cap_byte[ncap] = sh; cap_ack[ncap] = b; ncap++; end
               if (nbyte == 0) rseg = sh[0];
               nbyte++; bitcnt = 0;
            end
         end else if (pscl && !cscl) begin
            if (bitcnt == 8)
               slave_drv = (rseg && nbyte >= 1) ? 1'b1 : (nack_addr && nbyte == 0);
            else if (rseg && nbyte >= 1 && nbyte <= nrd)
               slave_drv = rdata[nbyte-1][7-bitcnt];
            else
               slave_drv = 1'b1;
         end
         pscl = cscl; psda = csda;
      end
   endtask

   initial begin
      logic [7:0] exp_w [4];
      logic [7:0] exp_s [7];
      logic       flag;
      exp_w = '{8'h72, 8'h41, 8'h10, 8'h20};
      exp_s = '{8'h72, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      rst_n = 1'b0; start_v = 1'b0; rw_v = 1'b0; sel = 1'b0; slave_drv = 1'b1;
      nack_addr = 1'b0; nrd = 0; saddr = 7'h39;
      reg1 = 8'h00; wd1 = 16'h0000; reg2 = 16'h0000; wd2 = 32'h0;
      for (int i = 0; i < 8; i++) rdata[i] = 8'hFF;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sda", sdao1, 1'b1);  chk("rst_scl", scl1, 1'b1);
      chk("rst_busy", busy1, 1'b0); chk("rst_done", done1, 1'b0);
      chk("rst_nack", nack1, 1'b0); chk("rst_rd", rd1, 16'h0000);
      chk("rst_busy2", busy2, 1'b0); chk("rst_rd2", rd2, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Default write
      reg1 = 8'h41; wd1 = 16'h1020; rw_v = 1'b0; start_v = 1'b1;
      run(152, 1, -5, -5);
      chk("wr_ncap", ncap, 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("wr_byte%0d", i), cap_byte[i], exp_w[i]);
         chk($sformatf("wr_ack%0d", i), cap_ack[i], 1'b0);
      end
      chk("wr_done_t", tdone, 150);   chk("wr_ndone", ndone, 1);
      chk("wr_busy_t1", busy_tr[1], 1'b1); chk("wr_busy_t150", busy_tr[150], 1'b1);
      chk("wr_busy_t151", busy_tr[151], 1'b0);
      chk("wr_starts", nstart, 1);    chk("wr_stops", nstop, 1);
      chk("wr_nack", nack1, 1'b0);
      chk("wr_t1_sda", sda_tr[1], 1'b0); chk("wr_t2_scl", scl_tr[2], 1'b0);

      // Default read
      reg1 = 8'h00; rw_v = 1'b1; rdata[0] = 8'hA5; rdata[1] = 8'h3C; nrd = 2; start_v = 1'b1;
      run(192, 1, -5, -5);
      chk("rd_ncap", ncap, 5);
      chk("rd_b0", cap_byte[0], 8'h72); chk("rd_b1", cap_byte[1], 8'h00);
      chk("rd_b2", cap_byte[2], 8'h73); chk("rd_b3", cap_byte[3], 8'hA5);
      chk("rd_b4", cap_byte[4], 8'h3C);
      chk("rd_ack3", cap_ack[3], 1'b0); chk("rd_ack4", cap_ack[4], 1'b1);
      chk("rd_t75", {sda_tr[75], scl_tr[75]}, 2'b10);
      chk("rd_t76", {sda_tr[76], scl_tr[76]}, 2'b11);
      chk("rd_t77", {sda_tr[77], scl_tr[77]}, 2'b01);
      chk("rd_t78", {sda_tr[78], scl_tr[78]}, 2'b00);
      chk("rd_starts", nstart, 2);
      chk("rd_done_t", tdone, 190);
      chk("rd_data", rd1, 16'hA53C);
      chk("rd_nack", nack1, 1'b0);

      // Address NACK on a read: abort, read_data kept
      nack_addr = 1'b1; rw_v = 1'b1; start_v = 1'b1;
      run(45, 1, -5, -5);
      chk("nk_t39", {sda_tr[39], scl_tr[39]}, 2'b00);
      chk("nk_t40", {sda_tr[40], scl_tr[40]}, 2'b01);
      chk("nk_t41", {sda_tr[41], scl_tr[41]}, 2'b11);
      chk("nk_done_t", tdone, 42);
      chk("nk_ncap", ncap, 1); chk("nk_ack0", cap_ack[0], 1'b1);
      chk("nk_sticky", nack1, 1'b1);
      chk("nk_rd_kept", rd1, 16'hA53C);
      nack_addr = 1'b0;

      // start pulse during busy is ignored; nack cleared when start accepted
      rw_v = 1'b0; start_v = 1'b1;
      run(160, 1, 20, -5);
      chk("pl_nack_clr", nack_tr[1], 1'b0);
      chk("pl_done_t", tdone, 150); chk("pl_ndone", ndone, 1);
      flag = 1'b0;
      for (int t = 151; t <= 160; t++) flag = flag | busy_tr[t];
      chk("pl_idle_after", flag, 1'b0);

      // Reset mid-transfer at t60
      start_v = 1'b1;
      run(69, 1, -5, 60);
      chk("mr_t61", {sda_tr[61], scl_tr[61]}, 2'b11);
      chk("mr_busy", busy_tr[61], 1'b0); chk("mr_nack", nack_tr[61], 1'b0);
      chk("mr_ndone", ndone, 0);
      start_v = 1'b1;
      run(152, 1, -5, -5);
      chk("mr2_ncap", ncap, 4);
      chk("mr2_b0", cap_byte[0], 8'h72); chk("mr2_b3", cap_byte[3], 8'h20);
      chk("mr2_done_t", tdone, 150);

      // start held high: back-to-back transfers
      start_v = 1'b1;
      run(303, 152, -5, -5);
      chk("hd_done_t", tdone, 150);
      chk("hd_busy151", busy_tr[151], 1'b0);
      chk("hd_t152", {busy_tr[152], sda_tr[152], scl_tr[152]}, 3'b101);
      chk("hd_done2_t", tdone2, 301); chk("hd_ndone", ndone, 2);

      // Parameter sweep instance: 2 register bytes, 4 data bytes
      sel = 1'b1; reg2 = 16'h1234; wd2 = 32'hDEADBEEF; rw_v = 1'b0; start_v = 1'b1;
      run(260, 1, -5, -5);
      chk("sw_ncap", ncap, 7);
      for (int i = 0; i < 7; i++) chk($sformatf("sw_byte%0d", i), cap_byte[i], exp_s[i]);
      chk("sw_done_t", tdone, 258);
      chk("sw_nack", nack2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/i2c_master_multibyte.md
# i2c_master_multibyte

Parametrised I2C master that replaces the fixed two-byte writer with configurable register-address and data lengths. It supports write transfers and register reads: a write-pointer phase, then a repeated START and a read phase. Per-byte slave ACK is checked and the transfer aborts on NACK. The block sits between the HDMI transmitter configuration sequencer and the open-drain pad logic, and runs one state step per cycle of the 100 kHz tick clock.

## Interface
- REG_BYTES, 1: register-address bytes sent after the slave address, range 1–4.
- DATA_BYTES, 2: data bytes written or read, range 1–8.
- CHECK_ACK, 1: 1 aborts the transfer on a slave NACK; 0 ignores ACK bits.
- clock_100khz  in  1  one clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low.
- start  in  1  level; sampled only in IDLE.
- rw  in  1  0 = write, 1 = read.
- slave_address  in  7  7-bit slave address.
- reg_address  in  8*REG_BYTES  register address; most significant byte is sent first.
- write_data  in  8*DATA_BYTES  write payload; most significant byte is sent first.
- read_data  out  8*DATA_BYTES  read result; the first received byte lands in the most significant byte.
- busy  out  1  high from START_A through DONE.
- done  out  1  one-cycle pulse in DONE.
- nack  out  1  sticky NACK flag; cleared when the next start is accepted.
- i2c_serial_data_input  in  1  sampled SDA.
- i2c_serial_data_output  out  1  SDA drive; 1 = release.
- i2c_serial_clock  out  1  SCL.

## Operation
- Reset (reset = 0 at an edge) puts the block in IDLE with: SDA = 1, SCL = 1, busy = 0, done = 0, nack = 0, read_data = 0.
  - Reset wins over every other condition.
  - Reset mid-transfer abandons the bus without generating a STOP.
- IDLE:
  - Outputs: SDA = 1, SCL = 1.
  - When start = 1, latch rw, slave_address, reg_address and write_data, clear nack, and go to START_A.
  - start is ignored while busy.
- START_A: SDA = 0, SCL = 1. START_B: SDA = 0, SCL = 0.
- Byte slot: 8 data bits MSB first, then 1 ACK bit. Each bit takes 4 cycles:
  - P0: SCL = 0, SDA driven.
  - P1: SCL = 1.
  - P2: SCL = 1, i2c_serial_data_input sampled.
  - P3: SCL = 0.
- Write sequence: START, address byte {slave_address, 0}, REG_BYTES register bytes, DATA_BYTES data bytes, STOP.
- Read sequence:
  - START, address byte {slave_address, 0}, REG_BYTES register bytes.
  - Repeated START:
    - RS_A: SDA = 1, SCL = 0.
    - RS_B: SDA = 1, SCL = 1.
    - RS_C: SDA = 0, SCL = 1.
    - Then START_B.
  - Address byte {slave_address, 1}, then DATA_BYTES received bytes, then STOP.
- ACK slot after a transmitted byte:
  - Master drives SDA = 1 (released) for the whole slot.
  - Input sampled at P2: 0 = ACK, 1 = NACK.
- ACK slot after a received byte:
  - Master drives SDA = 0 (ACK) after every byte except the last.
  - After the last byte it drives SDA = 1 (NACK).
- On NACK with CHECK_ACK = 1: set nack = 1, skip the remaining bytes, and go to STOP_A after P3 of that slot.
- STOP:
  - STOP_A: SDA = 0, SCL = 0.
  - STOP_B: SDA = 0, SCL = 1.
  - STOP_C: SDA = 1, SCL = 1.
- DONE:
  - done = 1 for this one cycle.
  - read_data is updated here only for a read that completed without NACK; otherwise read_data holds its previous value.
  - Next state is IDLE.
- If start is still high in IDLE after DONE, a new transfer starts immediately.

## Timing
- SDA changes only in cycles where SCL = 0, except in the START, repeated-START and STOP states.
- Cycle numbering: t0 is the IDLE cycle in which start is sampled high.
  - Byte slot = 36 cycles.
  - START_A at t1, START_B at t2, first bit P0 at t3.
- Write latency: done at t(3 + 36·(1 + REG_BYTES + DATA_BYTES) + 3).
  - Defaults: done at t150; busy high t1–t150.
- Read latency: done at t(3 + 36·(1 + REG_BYTES) + 4 + 36·(1 + DATA_BYTES) + 3).
  - Defaults: repeated START at t75–t77, START_B at t78, done at t190.
- NACK on the address byte: STOP_A at t39, done at t42.
- busy falls and IDLE is entered on the cycle after DONE.

## Test plan
- Write, defaults: addr 0x39, reg 0x41, data 0x1020, slave always ACKs.
  - Bus carries bytes 0x72, 0x41, 0x10, 0x20; done at t150; nack = 0.
- Read, defaults: addr 0x39, reg 0x00, slave model returns 0xA5 then 0x3C.
  - Repeated START at t75; bytes 0x72, 0x00, 0x73 on the bus; master ACKs byte 1 and NACKs byte 2.
  - read_data = 0xA53C at done, t190.
- Address NACK: slave drives SDA = 1 in the first ACK slot.
  - nack = 1; STOP at t39–t41; done at t42; read_data unchanged.
- Reset mid-transfer: reset = 0 at t60.
  - Next cycle: SDA = 1, SCL = 1, busy = 0, nack = 0, done never pulses.
  - start at t70 begins a clean transfer.
- start pulsed during busy is ignored, with no extra transfer.
  - With start held high, a second transfer's START_A occurs 2 cycles after done.
- Parameter sweep: REG_BYTES = 2, DATA_BYTES = 4, write.
  - 7 bytes on the bus; done at t(3 + 252 + 3) = t258.
